interrupt_request_controller: RTL
=================================

# interrupt_request_controller

Sits upstream of the pipelined processor top level and drives its single-bit `interrupt` input. Latches rising edges from several external request lines and applies a software-writable mask. Picks the highest-priority eligible source and issues a fixed-length interrupt pulse to the core. Withholds further pulses until the core signals return-from-interrupt, so the fetch stage and saved-flags logic only see one interrupt per service window.

## Interface
- `NUM_SRC`, default 4: number of request lines (1..8).
- `PULSE_LEN`, default 2: cycles `interrupt` is held high per grant (1..15).
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `irq_req`  in  NUM_SRC  external request lines; rising edge = request.
- `mask_we`  in  1  write strobe for mask register.
- `mask_data`  in  NUM_SRC  new mask value; bit=1 enables source.
- `irq_ret`  in  1  one-cycle pulse from core on return-from-interrupt.
- `interrupt`  out  1  to core `interrupt` input.
- `irq_id`  out  3  index of granted source; valid from first pulse cycle until return.
- `pending`  out  NUM_SRC  current pending bits.
- `busy`  out  1  high in ASSERT and SERVICE.

## Operation
- Reset (synchronous, active-high) clears:
  - `interrupt`, `irq_id`, `pending`, `busy`;
  - the edge-detect history register;
  - the pulse counter.
- Reset sets mask to all ones and FSM to IDLE.
- Edge detect: `rise = irq_req & ~prev`; `prev <= irq_req` every cycle.
- Pending: `pending <= (pending & ~clr) | rise`.
  - `clr` is the one-hot of the granted source on the grant cycle.
  - A rise on the same source in the same cycle wins; the bit stays set.
- Repeated edges on an already-pending source are not counted.
- Masked sources still latch pending but are ineligible.
  - Unmasking makes a latched bit eligible on the next IDLE evaluation.
- Eligible vector = `pending & mask`.
  - Priority: lowest index wins.
- Mask write: mask takes `mask_data` at the edge where `mask_we`=1.
  - The new mask is used from the following cycle.
- FSM:
  - IDLE: if eligible ≠ 0 → ASSERT. On this edge:
    - `irq_id` = winner;
    - the winner's pending bit is cleared;
    - `interrupt` <= 1, `busy` <= 1, counter <= PULSE_LEN-1.
  - ASSERT: counter decrements each cycle. When counter=0:
    - `interrupt` <= 0;
    - FSM → SERVICE.
  - SERVICE: `irq_ret`=1 → IDLE, with `busy` <= 0 and `irq_id` <= 0.
- `irq_ret` in IDLE or ASSERT is ignored; it is not stored.
- `irq_ret` and a new eligible request in the same SERVICE cycle:
  - the FSM goes to IDLE;
  - the grant happens on the next edge, so there is one idle cycle minimum between pulses.
- Reset asserted in ASSERT or SERVICE aborts immediately.
  - `interrupt` is 0 after that edge.
  - The in-flight grant is lost.

## Timing
- Request latency, without the synchronizer:
  - `irq_req` rises before edge k;
  - pending bit set after edge k;
  - `interrupt`=1 after edge k+1;
  - `interrupt` stays high for exactly PULSE_LEN cycles.
- `irq_id` and `busy` change on the same edge as `interrupt` rising.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Minimum spacing between pulse starts is PULSE_LEN + 2 cycles:
  - ASSERT cycles;
  - one SERVICE cycle with `irq_ret`;
  - one IDLE cycle.

## Configuration
- `IRQ_INPUT_SYNC_EN` defined:
  - each `irq_req` bit passes through a two-flop synchronizer before edge detect;
  - request latency grows by 2 cycles (`interrupt` after edge k+3);
  - synchronizer flops clear on reset.
- Not defined: `irq_req` feeds edge detect directly, with the latency given in Timing.

## Test plan
- Reset, then `irq_req`=4'b0001 at cycle 5:
  - `pending`=0001 after edge 5;
  - `interrupt`=1 for cycles 6–7 (PULSE_LEN=2), `irq_id`=0, `busy`=1;
  - `pending`=0000 after edge 6.
- `irq_req`=4'b0110 rising together:
  - grant `irq_id`=1, `pending`=0100 during service;
  - after `irq_ret`, one idle cycle, then a second pulse with `irq_id`=2.
- Mask written to 4'b1110, then `irq_req[0]` rises:
  - `pending`=0001, no pulse;
  - mask written to 4'b1111: pulse with `irq_id`=0 two cycles after the write edge.
- `irq_ret` pulsed during ASSERT: ignored, FSM stays in SERVICE until a later `irq_ret`.
  - Also: a second rise on source 3 while source 3 is pending yields only one grant.
- Reset asserted during the second ASSERT cycle:
  - all outputs 0 on the next edge;
  - mask=1111;
  - no pulse resumes without a new edge.
- With `IRQ_INPUT_SYNC_EN` defined, repeat the first scenario: `interrupt` high for cycles 8–9.

Source files
------------

// File: rtl/interrupt_request_controller.sv
// rtl/interrupt_request_controller.sv - edge-latched, masked, priority interrupt pulse generator (optional IRQ_INPUT_SYNC_EN input synchronizer)
module interrupt_request_controller #(
    parameter int NUM_SRC   = 4,
    parameter int PULSE_LEN = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_req,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_data,
    input  logic               irq_ret,
    output logic               interrupt,
    output logic [2:0]         irq_id,
    output logic [NUM_SRC-1:0] pending,
    output logic               busy
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ASSERT  = 2'd1;
    localparam logic [1:0] S_SERVICE = 2'd2;
    localparam logic [3:0] CNT_INIT  = 4'(PULSE_LEN - 1);

    logic [1:0]         state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               int_q, int_d;
    logic [2:0]         id_q, id_d;
    logic               busy_q, busy_d;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [NUM_SRC-1:0] prev_q;
    logic [NUM_SRC-1:0] req_s;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] win_onehot;
    logic [2:0]         win_id;

`ifdef IRQ_INPUT_SYNC_EN
    logic [NUM_SRC-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_req;
            sync2_q <= sync1_q;
        end
    end

    assign req_s = sync2_q;
`else
    assign req_s = irq_req;
`endif

    assign rise     = req_s & ~prev_q;
    assign eligible = pend_q & mask_q;

    // Scan from the top so the lowest eligible index is the last one written.
    always_comb begin
        win_id     = '0;
        win_onehot = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_id        = 3'(i);
                win_onehot    = '0;
                win_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        int_d   = int_q;
        id_d    = id_q;
        busy_d  = busy_q;
        clr     = '0;
        case (state_q)
            S_IDLE: begin
                if (|eligible) begin
                    state_d = S_ASSERT;
                    id_d    = win_id;
                    clr     = win_onehot;
                    int_d   = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = CNT_INIT;
                end
            end
            S_ASSERT: begin
                if (cnt_q == 4'd0) begin
                    int_d   = 1'b0;
                    state_d = S_SERVICE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_SERVICE: begin
                if (irq_ret) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    id_d    = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A fresh rise on the granted source keeps its pending bit set.
        pend_d = (pend_q & ~clr) | rise;
        mask_d = mask_we ? mask_data : mask_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            int_q   <= 1'b0;
            id_q    <= '0;
            busy_q  <= 1'b0;
            pend_q  <= '0;
            mask_q  <= '1;
            prev_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            int_q   <= int_d;
            id_q    <= id_d;
            busy_q  <= busy_d;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            prev_q  <= req_s;
        end
    end

    assign interrupt = int_q;
    assign irq_id    = id_q;
    assign pending   = pend_q;
    assign busy      = busy_q;

endmodule
